// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring 32-bit divider with one-cycle ready pulse
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, dvd, dsr;
    logic             neg_q, neg_r;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_n, dvd_n;
    logic             last, accept;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    // Partial remainder stays below the divisor, so the MSB of the
    // WIDTH+1-bit difference is a reliable borrow flag.
    assign shifted = {rem, dvd[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr};
    assign rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_n   = {dvd[WIDTH-2:0], ~diff[WIDTH]};
    assign last    = (cnt == CW'(WIDTH - 1));
    assign accept  = start_i && !annul_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FREE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            FREE:    if (accept) state_n = (opdata2_i == '0) ? BYZERO : ON;
            BYZERO:  state_n = annul_i ? FREE : END;
            ON: begin
                if (annul_i)   state_n = FREE;
                else if (last) state_n = END;
            end
            END:     state_n = FREE;
            default: state_n = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                FREE: begin
                    if (accept) begin
                        dvd   <= mag(opdata1_i, signed_div_i);
                        dsr   <= mag(opdata2_i, signed_div_i);
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
                BYZERO: begin
                    if (!annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                ON: begin
                    if (!annul_i) begin
                        rem <= rem_n;
                        dvd <= dvd_n;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            result_o <= {neg_r ? -rem_n : rem_n, neg_q ? -dvd_n : dvd_n};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks;
    int errors;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a request in cycle 0 and holds it until the ready pulse has been seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input int max_cycles, output int rc, output int npulse,
                          output logic [63:0] res);
        op1 = a; op2 = b; signed_div = sg; start = 1'b1;
        rc = -1; npulse = 0; res = '0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (ready) begin
                npulse++;
                if (rc < 0) begin
                    rc  = c;
                    res = result;
                end
            end
            @(posedge clk); #1;
            if (rc >= 0) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++;
        if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int rc, np; logic [63:0] r;
        run_op(32'd100, 32'd7, 1'b0, 40, rc, np, r);
        checks++;
        if (rc !== 33) begin errors++; $display("FAIL udiv_latency got %0d want 33", rc); end
        checks++;
        if (np !== 1) begin errors++; $display("FAIL udiv_pulses got %0d want 1", np); end
        checks++;
        if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_100_7 got %h want %h", r, {32'd2, 32'd14}); end
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 40, rc, np, r);
        checks++;
        if (r !== {32'd1, 32'h7FFF_FFFC}) begin errors++; $display("FAIL udiv_fff9_2 got %h want %h", r, {32'd1, 32'h7FFF_FFFC}); end
    endtask

    task automatic test_signed();
        int rc, np; logic [63:0] r;
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 40, rc, np, r);
        checks++;
        if (rc !== 33) begin errors++; $display("FAIL sdiv_latency got %0d want 33", rc); end
        checks++;
        if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL sdiv_m7_2 got %h want %h", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 40, rc, np, r);
        checks++;
        if (r !== {32'd0, 32'h8000_0000}) begin errors++; $display("FAIL sdiv_overflow got %h want %h", r, {32'd0, 32'h8000_0000}); end
    endtask

    task automatic test_div_zero();
        int rc, np; logic [63:0] r;
        run_op(32'd5, 32'd0, 1'b0, 8, rc, np, r);
        checks++;
        if (rc !== 2) begin errors++; $display("FAIL divzero_latency got %0d want 2", rc); end
        checks++;
        if (np !== 1) begin errors++; $display("FAIL divzero_pulses got %0d want 1", np); end
        checks++;
        if (r !== 64'd0) begin errors++; $display("FAIL divzero_result got %h want 0", r); end
    endtask

    task automatic test_annul();
        int rc, np, seen; logic [63:0] r;
        run_op(32'd100, 32'd7, 1'b0, 40, rc, np, r);
        op1 = 32'd1000; op2 = 32'd3; signed_div = 1'b0; start = 1'b1; seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) seen++;
            @(posedge clk); #1;
            if (c == 9) begin annul = 1'b1; start = 1'b0; end
            if (c == 10) annul = 1'b0;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL annul_pulses got %0d want 0", seen); end
        checks++;
        if (result !== {32'd2, 32'd14}) begin errors++; $display("FAIL annul_keep got %h want %h", result, {32'd2, 32'd14}); end
        run_op(32'd9, 32'd3, 1'b0, 40, rc, np, r);
        checks++;
        if (rc !== 33) begin errors++; $display("FAIL annul_fresh_latency got %0d want 33", rc); end
        checks++;
        if (r !== {32'd0, 32'd3}) begin errors++; $display("FAIL annul_fresh_9_3 got %h want %h", r, {32'd0, 32'd3}); end
    endtask

    task automatic test_back_to_back();
        int np, c1, c2; logic [63:0] r1, r2;
        op1 = 32'd20; op2 = 32'd6; signed_div = 1'b0; start = 1'b1;
        np = 0; c1 = -1; c2 = -1; r1 = '0; r2 = '0;
        for (int c = 0; c < 76; c++) begin
            @(negedge clk);
            if (ready) begin
                np++;
                if (c1 < 0) begin c1 = c; r1 = result; end
                else if (c2 < 0) begin c2 = c; r2 = result; end
            end
            @(posedge clk); #1;
            if (c == 33) begin op1 = 32'd15; op2 = 32'd4; end
            if (c == 67) start = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (np !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", np); end
        checks++;
        if (c1 !== 33) begin errors++; $display("FAIL b2b_first_cycle got %0d want 33", c1); end
        checks++;
        if (c2 !== 67) begin errors++; $display("FAIL b2b_second_cycle got %0d want 67", c2); end
        checks++;
        if (r1 !== {32'd2, 32'd3}) begin errors++; $display("FAIL b2b_20_6 got %h want %h", r1, {32'd2, 32'd3}); end
        checks++;
        if (r2 !== {32'd3, 32'd3}) begin errors++; $display("FAIL b2b_15_4 got %h want %h", r2, {32'd3, 32'd3}); end
    endtask

    task automatic test_reset_mid();
        int rc, np; logic [63:0] r;
        op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (17) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b want 0", ready); end
        checks++;
        if (result !== 64'd0) begin errors++; $display("FAIL midreset_result got %h want 0", result); end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(32'd77, 32'd10, 1'b0, 40, rc, np, r);
        checks++;
        if (rc !== 33) begin errors++; $display("FAIL postreset_latency got %0d want 33", rc); end
        checks++;
        if (r !== {32'd7, 32'd7}) begin errors++; $display("FAIL postreset_77_10 got %h want %h", r, {32'd7, 32'd7}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Sequential 32-bit integer divider for the execute stage, and the producer side of the divide stall handshake. The E-stage asserts `start_i` for DIV/DIVU and holds the instruction while `ready_o` is low; the hazard logic stalls F/D/E on `is_div & ~ready_o`. `div_unit` computes quotient and remainder by radix-2 restoring division, one bit per cycle. It asserts `ready_o` for exactly one cycle with the result, so the pipeline advances on that edge.

## Interface
- `WIDTH`, 32, operand width; quotient and remainder are each `WIDTH` bits.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start_i`  in  1  divide request from the E-stage, held high for the whole stall.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with the operands.
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `annul_i`  in  1  abort: E-stage flush or exception.
- `result_o`  out  2*WIDTH  {remainder[63:32] (HI), quotient[31:0] (LO)}; registered.
- `ready_o`  out  1  result valid; one-cycle pulse, registered.

## Operation
- States: FREE, BYZERO, ON, END. Reset values: state = FREE, `ready_o` = 0, `result_o` = 0, iteration counter = 0.
- FREE:
  - `start_i & ~annul_i` latches the operands and `signed_div_i`.
  - Divisor == 0 → BYZERO.
  - Otherwise → ON with the counter cleared.
  - `annul_i` high in FREE suppresses the start.
- Signed mode:
  - Operands are converted to magnitudes at latch time.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps) and remainder 0.
- ON:
  - Each edge shifts the {partial remainder, dividend} register left by 1 and trial-subtracts the divisor (WIDTH+1 bits).
  - If the difference is non-negative, it replaces the partial remainder and the quotient bit is 1.
  - After iteration WIDTH, sign-correct and write `result_o`, then → END.
- BYZERO: next edge writes `result_o` = 0 and → END.
- END:
  - `ready_o` = 1 for this single cycle.
  - Next edge → FREE unconditionally and `ready_o` = 0.
  - `start_i` during END is ignored.
- `annul_i` high in ON or BYZERO → FREE on the next edge. No `ready_o`, and `result_o` is unchanged.
- Operand changes after the latch have no effect.
- `result_o` holds its last value until the next completed divide.
- An async `rst` low at any time forces the reset values immediately, including mid-divide.

## Timing
- Cycle n is the period after edge n.
- `start_i` sampled high in FREE at edge 1 → ON in cycle 1. Iterations occur on edges 2..33 (32 cycles), and `ready_o` = 1 in cycle 33.
- A requesting instruction is therefore stalled in E for 34 cycles total (cycles 0..33).
- Divide-by-zero: start sampled at edge 1 → BYZERO in cycle 1, `ready_o` = 1 in cycle 2.
- Back-to-back divides: END in cycle 33, FREE in cycle 34. The following DIV, now in E, is sampled at edge 35 (ready in cycle 67). No divide is ever started twice from one request.
- `ready_o` and `result_o` change only on clock edges or async reset; they have no combinational path from the inputs.

## Test plan
- Unsigned 100 / 7:
  - start in cycle 0 → `ready_o` = 1 only in cycle 33.
  - `result_o` = {32'd2, 32'd14}.
  - `ready_o` = 0 in cycles 0..32 and 34.
- Signed −7 / 2 → `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}. The same bit patterns as DIVU (0xFFFFFFF9 / 2) → {0x00000001, 0x7FFFFFFC}.
- Divide by zero (5 / 0):
  - `ready_o` = 1 in cycle 2 and `result_o` = 0.
  - Signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Annul:
  - `annul_i` pulsed in cycle 10 of a divide → FREE, no `ready_o` pulse, `result_o` keeps its prior value.
  - A fresh 9 / 3 start then yields {0, 3} in 33 cycles.
- Back-to-back:
  - Hold `start_i` high across two requests (20/6 then 15/4) → ready pulses in cycles 33 and 67.
  - Results {2, 3} then {3, 3}; each pulse is exactly one cycle.
- Reset mid-operation: drive `rst` low asynchronously in cycle 17 → `ready_o`/`result_o` = 0 immediately, state FREE; after release, a new divide completes normally.
